// File: rtl/wb_port_arbiter_if.sv
// Write-port bundle between the WB stage, the multi-cycle unit and the register file.
// The arbiter uses the slave view; the surrounding pipeline uses the master view.
interface wb_port_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            pipe_we;
  logic [AW-1:0]   pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            mc_valid;
  logic            mc_ready;
  logic [AW-1:0]   mc_rd;
  logic [XLEN-1:0] mc_data;
  logic            rf_we;
  logic [AW-1:0]   rf_rd;
  logic [XLEN-1:0] rf_data;
  logic            pipe_stall;

  modport slave (
    input  pipe_we, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
    output mc_ready, rf_we, rf_rd, rf_data, pipe_stall
  );

  modport master (
    output pipe_we, pipe_rd, pipe_data, mc_valid, mc_rd, mc_data,
    input  mc_ready, rf_we, rf_rd, rf_data, pipe_stall
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the pipeline (priority) and a multi-cycle
// unit, using a one-entry holding buffer and a starvation counter that forces a drain.
module wb_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int AW           = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  wb_port_arbiter_if.slave bus
);

  localparam int            CW      = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    FORCE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
  logic [AW-1:0]   buf_rd;
  logic [XLEN-1:0] buf_data;
  logic            buf_valid;
  logic            buf_load;
  logic            slot_busy;

  logic            we_nxt;
  logic [AW-1:0]   rd_nxt;
  logic [XLEN-1:0] data_nxt;

  // The buffer is occupied exactly when the FSM is outside IDLE.
  assign buf_valid      = (state != IDLE);
  assign slot_busy      = bus.pipe_we && (bus.pipe_rd != '0) && (state != FORCE);
  assign cnt_inc        = cnt + 1'b1;
  assign bus.mc_ready   = !buf_valid;
  assign bus.pipe_stall = (state == FORCE);

  // NOTE: every variable gets a default before any branch so no latch is inferred.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    buf_load  = 1'b0;
    we_nxt    = 1'b0;
    rd_nxt    = bus.rf_rd;
    data_nxt  = bus.rf_data;

    if (state == FORCE) begin
      // Pipeline is frozen this cycle; the stale-proof buffered entry owns the port.
      we_nxt    = 1'b1;
      rd_nxt    = buf_rd;
      data_nxt  = buf_data;
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (slot_busy) begin
      we_nxt   = 1'b1;
      rd_nxt   = bus.pipe_rd;
      data_nxt = bus.pipe_data;
      if (state == IDLE) begin
        if (bus.mc_valid && (bus.mc_rd != '0)) begin
          buf_load  = 1'b1;
          state_nxt = HOLD;
          cnt_nxt   = '0;
        end
      end else if (bus.pipe_rd == buf_rd) begin
        // Younger pipeline write to the same register makes the buffered value dead.
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt_inc;
        if (cnt_inc == LIMIT_C) begin
          state_nxt = FORCE;
        end
      end
    end else if (buf_valid) begin
      we_nxt    = 1'b1;
      rd_nxt    = buf_rd;
      data_nxt  = buf_data;
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else if (bus.mc_valid) begin
      // Bypass: result goes straight to the port; a zero destination is simply dropped.
      we_nxt   = (bus.mc_rd != '0);
      rd_nxt   = bus.mc_rd;
      data_nxt = bus.mc_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      bus.rf_we   <= 1'b0;
      bus.rf_rd   <= '0;
      bus.rf_data <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      bus.rf_we   <= we_nxt;
      bus.rf_rd   <= rd_nxt;
      bus.rf_data <= data_nxt;
    end
  end

  // NOTE: the buffer payload is not reset; it is only observed while the FSM is outside IDLE.
  always_ff @(posedge clk) begin
    if (buf_load) begin
      buf_rd   <= bus.mc_rd;
      buf_data <= bus.mc_data;
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: literal expectations plus a per-cycle comparison
// against a buffer-occupancy/age model of the port-sharing rules.
module tb_wb_port_arbiter;

  localparam int XLEN         = 32;
  localparam int AW           = 5;
  localparam int STARVE_LIMIT = 4;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wb_port_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus ();

  wb_port_arbiter #(
    .XLEN(XLEN), .AW(AW), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an entry waiting for the port has an age (cycles since capture); once it has
  // waited STARVE_LIMIT blocked cycles, the following cycle belongs to it with the pipeline frozen.
  bit              m_ok = 0;
  bit              m_full = 0;
  int              m_age = 0;
  logic [AW-1:0]   m_rd = '0;
  logic [XLEN-1:0] m_data = '0;
  logic            e_we = 0;
  logic [AW-1:0]   e_rd = '0;
  logic [XLEN-1:0] e_data = '0;

  function automatic bit m_stall();
    return m_full && (m_age == STARVE_LIMIT + 1);
  endfunction

  always @(posedge clk) begin
    bit busy;
    busy = bus.pipe_we && (bus.pipe_rd != 0) && !m_stall();
    if (reset) begin
      m_ok = 1; m_full = 0; m_age = 0;
      e_we = 0; e_rd = '0; e_data = '0;
    end else if (m_stall()) begin
      e_we = 1; e_rd = m_rd; e_data = m_data; m_full = 0;
    end else if (busy) begin
      e_we = 1; e_rd = bus.pipe_rd; e_data = bus.pipe_data;
      if (m_full) begin
        if (bus.pipe_rd == m_rd) m_full = 0;
        else m_age++;
      end else if (bus.mc_valid && bus.mc_rd != 0) begin
        m_full = 1; m_age = 1; m_rd = bus.mc_rd; m_data = bus.mc_data;
      end
    end else if (m_full) begin
      e_we = 1; e_rd = m_rd; e_data = m_data; m_full = 0;
    end else if (bus.mc_valid) begin
      e_we = (bus.mc_rd != 0); e_rd = bus.mc_rd; e_data = bus.mc_data;
    end else begin
      e_we = 0;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("cyc_rf_we", 32'(bus.rf_we), 32'(e_we));
      check("cyc_mc_ready", 32'(bus.mc_ready), 32'(!m_full));
      check("cyc_pipe_stall", 32'(bus.pipe_stall), 32'(m_stall()));
      if (e_we) begin
        check("cyc_rf_rd", 32'(bus.rf_rd), 32'(e_rd));
        check("cyc_rf_data", bus.rf_data, e_data);
      end
    end
  end

  task automatic cyc(input logic pw, input logic [AW-1:0] prd, input logic [XLEN-1:0] pd,
                     input logic mv, input logic [AW-1:0] mrd, input logic [XLEN-1:0] md);
    bus.pipe_we = pw; bus.pipe_rd = prd; bus.pipe_data = pd;
    bus.mc_valid = mv; bus.mc_rd = mrd; bus.mc_data = md;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc();
    cyc(0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    reset = 1;
    idle_cyc();
    idle_cyc();
    check("rst_rf_we", 32'(bus.rf_we), 0);
    check("rst_rf_rd", 32'(bus.rf_rd), 0);
    check("rst_rf_data", bus.rf_data, 0);
    check("rst_pipe_stall", 32'(bus.pipe_stall), 0);
    check("rst_mc_ready", 32'(bus.mc_ready), 1);
    reset = 0;
    idle_cyc();

    // Pipeline only, then rd=0 suppressed
    cyc(1, 5'd3, 32'hA5A5_0001, 0, '0, '0);
    check("pipe_we", 32'(bus.rf_we), 1);
    check("pipe_rd", 32'(bus.rf_rd), 3);
    check("pipe_data", bus.rf_data, 32'hA5A5_0001);
    cyc(1, 5'd0, 32'hDEAD_0000, 0, '0, '0);
    check("pipe_rd0_we", 32'(bus.rf_we), 0);

    // Bypass
    check("byp_ready", 32'(bus.mc_ready), 1);
    cyc(0, '0, '0, 1, 5'd7, 32'h0000_1234);
    check("byp_we", 32'(bus.rf_we), 1);
    check("byp_rd", 32'(bus.rf_rd), 7);
    check("byp_data", bus.rf_data, 32'h0000_1234);
    check("byp_ready_after", 32'(bus.mc_ready), 1);

    // Buffer and drain
    cyc(1, 5'd4, 32'h0000_0044, 1, 5'd9, 32'h0000_0099);
    check("buf_first_rd", 32'(bus.rf_rd), 4);
    check("buf_ready_low", 32'(bus.mc_ready), 0);
    idle_cyc();
    check("buf_drain_we", 32'(bus.rf_we), 1);
    check("buf_drain_rd", 32'(bus.rf_rd), 9);
    check("buf_drain_data", bus.rf_data, 32'h0000_0099);
    check("buf_ready_back", 32'(bus.mc_ready), 1);
    idle_cyc();
    check("buf_quiet", 32'(bus.rf_we), 0);

    // Starvation: capture at cycle 0, stall visible only in cycle 5
    cyc(1, 5'd1, 32'h0000_0100, 1, 5'd20, 32'h0000_2000);
    for (int i = 1; i <= 6; i++) begin
      check($sformatf("starve_stall_c%0d", i), 32'(bus.pipe_stall), 32'(i == 5));
      cyc(1, 5'(i + 1), 32'h0000_0100 + i, 0, '0, '0);
      if (i == 5) begin
        check("starve_buf_rd", 32'(bus.rf_rd), 20);
        check("starve_buf_data", bus.rf_data, 32'h0000_2000);
        check("starve_ready", 32'(bus.mc_ready), 1);
      end
    end
    check("starve_resume_rd", 32'(bus.rf_rd), 7);
    check("starve_resume_data", bus.rf_data, 32'h0000_0106);
    idle_cyc();

    // WAW discard
    cyc(1, 5'd11, 32'h0000_0011, 1, 5'd12, 32'h0000_000C);
    check("waw_ready_low", 32'(bus.mc_ready), 0);
    cyc(1, 5'd12, 32'h0000_BEEF, 0, '0, '0);
    check("waw_rd", 32'(bus.rf_rd), 12);
    check("waw_data", bus.rf_data, 32'h0000_BEEF);
    check("waw_ready_back", 32'(bus.mc_ready), 1);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 5'(13 + i), 32'h0000_0D00 + i, 0, '0, '0);
      check("waw_no_force", 32'(bus.pipe_stall), 0);
    end
    idle_cyc();
    check("waw_no_late_write", 32'(bus.rf_we), 0);

    // mc handshake with rd=0 while slot busy is dropped, not buffered
    cyc(1, 5'd2, 32'h0000_0002, 1, 5'd0, 32'hFFFF_FFFF);
    check("mcrd0_ready", 32'(bus.mc_ready), 1);
    idle_cyc();
    check("mcrd0_no_write", 32'(bus.rf_we), 0);

    // Reset mid-HOLD
    cyc(1, 5'd5, 32'h0000_0005, 1, 5'd14, 32'h0000_000E);
    check("rsth_ready_low", 32'(bus.mc_ready), 0);
    reset = 1;
    idle_cyc();
    check("rsth_we", 32'(bus.rf_we), 0);
    check("rsth_stall", 32'(bus.pipe_stall), 0);
    check("rsth_ready", 32'(bus.mc_ready), 1);
    reset = 0;
    for (int i = 0; i < 3; i++) begin
      idle_cyc();
      check("rsth_lost", 32'(bus.rf_we), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbitrates the single register-file write port between the in-order pipeline writeback stage and a multi-cycle execution unit (mul/div) that completes out of band. The pipeline always has priority. A one-entry holding buffer absorbs a multi-cycle result while the pipeline occupies the port, and a starvation counter stalls the pipeline to force a drain. The block sits between the WB stage output (write enable, rd, selected data) and the register file write inputs.

## Interface
- XLEN, 32, data width
- AW, 5, register address width
- STARVE_LIMIT, 4, blocked HOLD cycles tolerated before forcing a drain (≥1)

- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high
- pipe_we  in  1  pipeline writeback enable
- pipe_rd  in  AW  pipeline destination register
- pipe_data  in  XLEN  pipeline writeback data (post result mux)
- mc_valid  in  1  multi-cycle result valid
- mc_ready  out  1  buffer can accept a result; equals !buf_valid
- mc_rd  in  AW  multi-cycle destination register
- mc_data  in  XLEN  multi-cycle result
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  AW  register-file write address (registered)
- rf_data  out  XLEN  register-file write data (registered)
- pipe_stall  out  1  freeze pipeline, Moore output of FORCE state

## Operation
- Pipeline slot busy: pipe_we=1 and pipe_rd≠0 and state≠FORCE; otherwise the slot is free.
- Each cycle exactly one source is loaded into the rf_* registers, or none (rf_we←0):
  1. FORCE: buffer entry is written; pipeline inputs are ignored (held by stall).
  2. Slot busy: pipeline is written.
  3. Slot free, buf_valid: buffer is written and emptied.
  4. Slot free, buffer empty, mc_valid: mc result is written directly (bypass); the handshake completes and nothing is buffered.
- Capture: mc_valid && mc_ready && slot busy → buffer ← {mc_rd, mc_data}, buf_valid←1.
- Writes with rd=0 never assert rf_we. An mc handshake with mc_rd=0 completes and is discarded, never buffered.
- WAW: if the pipeline writes rd equal to the buffered rd, the buffered entry is stale and is discarded in that cycle (buf_valid←0).
- States:
  - IDLE (buffer empty): capture → HOLD, with cnt←0.
  - HOLD: buffer drained or discarded → IDLE. Otherwise cnt←cnt+1. When cnt+1 = STARVE_LIMIT, go to FORCE.
  - FORCE: one cycle only. Buffer drains, then IDLE, with cnt←0.
- mc_ready is low throughout HOLD and FORCE. No capture occurs while the buffer is full.
- reset: buffer is discarded, state←IDLE, cnt←0, and all rf_* registers clear. A pending mc result held at reset is lost; upstream is reset with the block.

## Timing
- Reset values: rf_we=0, rf_rd=0, rf_data=0, pipe_stall=0, mc_ready=1.
- Latency: source selected in cycle n appears on rf_* in cycle n+1.
- pipe_stall is high only in the FORCE cycle. Under continuous blocking it rises STARVE_LIMIT+1 cycles after the capture cycle.
- mc_ready is combinational from buf_valid only. It has no path from mc_valid.
- In the same cycle, a capture and a drain are mutually exclusive.
- A WAW discard takes precedence over a cnt increment and over the FORCE transition.

## Test plan
- Pipeline only: pipe_we=1, rd=3, data=0xA5A5_0001 at cycle n → rf_we=1, rf_rd=3, rf_data=0xA5A5_0001 at n+1. Also drive rd=0 → rf_we stays 0.
- Bypass: pipe_we=0, mc_valid=1, rd=7, data=0x1234 → mc_ready=1 and rf_we/rd=7/data=0x1234 next cycle. buf_valid stays 0.
- Buffer and drain: capture mc rd=9 while the pipeline writes rd=4. Drop pipe_we the next cycle → rd=4 written at n+1, rd=9 at n+2. mc_ready is low during cycle n+1 only.
- Starvation (STARVE_LIMIT=4): capture at cycle 0 with pipe_we held high and distinct rds → pipe_stall=1 at cycle 5 only, buffered write appears at cycle 6, and pipeline writes resume at cycle 7.
- WAW: buffer holds rd=12 and the pipeline writes rd=12 → only the pipeline value is written. The buffer empties, mc_ready returns to 1, and no FORCE occurs.
- Reset mid-HOLD: assert reset with buf_valid=1 → next cycle rf_we=0, pipe_stall=0, mc_ready=1, and the buffered value is never written.
